// File: rtl/taus_urng_bank.sv
// taus_urng_bank: multi-channel registered Tausworthe (three-component LFSR) uniform RNG.
// Every channel holds 3 x 32-bit state words. All channels step together and present one
// OUT_W-bit slice each on a valid/ready output register.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   en                 permits advancing; 0 freezes generator state
//   seed_we, seed_ch   load seed_s0/1/2 (after fix-up) into channel seed_ch; stalls one cycle
//   seed_s0..seed_s2   seed words
//   out_valid          out_data holds an unconsumed sample set
//   out_ready          consumer accepts when out_valid & out_ready
//   out_data           channel k in bits [k*OUT_W +: OUT_W]
//   out_count          accepted transfers, wraps modulo 2^32
module taus_urng_bank #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned OUT_W  = 32,
  parameter logic [31:0] SEED0  = 32'hF111F111,
  parameter logic [31:0] SEED1  = 32'h07770777,
  parameter logic [31:0] SEED2  = 32'hE888E888,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    seed_we,
  input  logic [CH_W-1:0]         seed_ch,
  input  logic [31:0]             seed_s0,
  input  logic [31:0]             seed_s1,
  input  logic [31:0]             seed_s2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*OUT_W-1:0] out_data,
  output logic [31:0]             out_count
);

  typedef enum logic {StEmpty, StFull} mode_e;

  mode_e mode_q, mode_d;

  logic [31:0] s0_q [NUM_CH];
  logic [31:0] s1_q [NUM_CH];
  logic [31:0] s2_q [NUM_CH];
  logic [31:0] s0_nxt [NUM_CH];
  logic [31:0] s1_nxt [NUM_CH];
  logic [31:0] s2_nxt [NUM_CH];

  logic [NUM_CH*OUT_W-1:0] data_q, data_nxt;
  logic [31:0]             count_q;
  logic                    hs, adv;

  // Raise degenerate components above the point where their LFSR would lock up.
  function automatic logic [31:0] fixup(logic [31:0] s, logic [31:0] lim);
    return (s < lim) ? s + lim : s;
  endfunction

  // One Tausworthe component step; all intermediates kept at 32 bits.
  function automatic logic [31:0] taus(logic [31:0] s, logic [31:0] mask,
                                       int unsigned sa, int unsigned sb, int unsigned sc);
    logic [31:0] t, b;
    t = (s << sa) ^ s;
    b = t >> sb;
    return ((s & mask) << sc) ^ b;
  endfunction

  // Per-channel decorrelation of the base reset seeds.
  function automatic logic [31:0] kmix(int unsigned k);
    return 32'(k) * 32'h9E3779B9;
  endfunction

  assign out_valid = (mode_q == StFull);
  assign out_data  = data_q;
  assign out_count = count_q;

  assign hs  = out_valid & out_ready;
  // Seed loads take priority over stepping so a seed never mixes with a step.
  assign adv = en & ~seed_we & (~out_valid | out_ready);

  always_comb begin
    logic [31:0] u;
    data_nxt = '0;
    u        = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      s0_nxt[k] = taus(s0_q[k], 32'hFFFF_FFFE, 13, 19, 12);
      s1_nxt[k] = taus(s1_q[k], 32'hFFFF_FFF8, 2, 25, 4);
      s2_nxt[k] = taus(s2_q[k], 32'hFFFF_FFF0, 3, 11, 17);
      u = s0_nxt[k] ^ s1_nxt[k] ^ s2_nxt[k];
      data_nxt[k*OUT_W +: OUT_W] = OUT_W'(u >> (32 - OUT_W));
    end
  end

  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      StEmpty: if (adv) mode_d = StFull;
      StFull:  if (hs && !adv) mode_d = StEmpty;
      default: mode_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= StEmpty;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      mode_q <= mode_d;
      if (adv) data_q <= data_nxt;
      if (hs) count_q <= count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (rst) begin
        s0_q[k] <= fixup(SEED0 ^ kmix(k), 32'd2);
        s1_q[k] <= fixup(SEED1 ^ kmix(k), 32'd8);
        s2_q[k] <= fixup(SEED2 ^ kmix(k), 32'd16);
      end else if (seed_we && (seed_ch == CH_W'(k))) begin
        s0_q[k] <= fixup(seed_s0, 32'd2);
        s1_q[k] <= fixup(seed_s1, 32'd8);
        s2_q[k] <= fixup(seed_s2, 32'd16);
      end else if (adv) begin
        s0_q[k] <= s0_nxt[k];
        s1_q[k] <= s1_nxt[k];
        s2_q[k] <= s2_nxt[k];
      end
    end
  end

endmodule

// File: tb/tb_taus_urng_bank.sv
// Bench for taus_urng_bank: a default instance (2 ch x 32 bit) and a 3 ch x 8 bit instance
// share stimulus and are checked every cycle against a transaction-level reference model.
module tb_taus_urng_bank;

  logic        clk = 1'b0;
  logic        rst, en, seed_we, out_ready;
  logic [1:0]  ch;
  logic [31:0] sd0, sd1, sd2;

  logic        a_valid, b_valid;
  logic [63:0] a_data;
  logic [23:0] b_data;
  logic [31:0] a_count, b_count;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  taus_urng_bank dut_a (
    .clk(clk), .rst(rst), .en(en), .seed_we(seed_we), .seed_ch(ch[0:0]),
    .seed_s0(sd0), .seed_s1(sd1), .seed_s2(sd2),
    .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data), .out_count(a_count)
  );

  taus_urng_bank #(.NUM_CH(3), .OUT_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .seed_we(seed_we), .seed_ch(ch),
    .seed_s0(sd0), .seed_s1(sd1), .seed_s2(sd2),
    .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data), .out_count(b_count)
  );

  // Reference model: index 0 = dut_a, 1 = dut_b.
  logic [31:0] ms0 [2][3];
  logic [31:0] ms1 [2][3];
  logic [31:0] ms2 [2][3];
  logic        mv [2];
  logic [95:0] md [2];
  logic [31:0] mc [2];

  function automatic int nch(int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int ow(int i);
    return (i == 0) ? 32 : 8;
  endfunction

  function automatic logic [31:0] fx(logic [31:0] s, logic [31:0] lim);
    return (s < lim) ? s + lim : s;
  endfunction

  function automatic logic [31:0] comp(logic [31:0] s, logic [31:0] mask,
                                       int a, int b, int c);
    logic [31:0] t, r;
    t = s << a;
    t = t ^ s;
    r = s & mask;
    r = r << c;
    return r ^ (t >> b);
  endfunction

  task automatic check_eq(string tag, logic [95:0] got, logic [95:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Apply the current inputs to the model as one clock edge.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic       hs, adv;
      int         c;
      logic [31:0] u;
      logic [95:0] nd;
      c = (i == 0) ? int'(ch[0]) : int'(ch);
      if (rst) begin
        mv[i] = 1'b0;
        md[i] = '0;
        mc[i] = '0;
        for (int k = 0; k < nch(i); k++) begin
          ms0[i][k] = fx(32'hF111F111 ^ (32'(k) * 32'h9E3779B9), 32'd2);
          ms1[i][k] = fx(32'h07770777 ^ (32'(k) * 32'h9E3779B9), 32'd8);
          ms2[i][k] = fx(32'hE888E888 ^ (32'(k) * 32'h9E3779B9), 32'd16);
        end
      end else begin
        hs  = mv[i] & out_ready;
        adv = en & ~seed_we & (~mv[i] | out_ready);
        if (seed_we && c < nch(i)) begin
          ms0[i][c] = fx(sd0, 32'd2);
          ms1[i][c] = fx(sd1, 32'd8);
          ms2[i][c] = fx(sd2, 32'd16);
        end
        if (adv) begin
          nd = '0;
          for (int k = 0; k < nch(i); k++) begin
            ms0[i][k] = comp(ms0[i][k], 32'hFFFF_FFFE, 13, 19, 12);
            ms1[i][k] = comp(ms1[i][k], 32'hFFFF_FFF8, 2, 25, 4);
            ms2[i][k] = comp(ms2[i][k], 32'hFFFF_FFF0, 3, 11, 17);
            u = ms0[i][k] ^ ms1[i][k] ^ ms2[i][k];
            nd = nd | (96'(u >> (32 - ow(i))) << (k * ow(i)));
          end
          md[i] = nd;
          mv[i] = 1'b1;
        end else if (hs) begin
          mv[i] = 1'b0;
        end
        if (hs) mc[i] = mc[i] + 32'd1;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("a_valid", 96'(a_valid), 96'(mv[0]));
    check_eq("a_data",  96'(a_data),  md[0]);
    check_eq("a_count", 96'(a_count), 96'(mc[0]));
    check_eq("b_valid", 96'(b_valid), 96'(mv[1]));
    check_eq("b_data",  96'(b_data),  md[1]);
    check_eq("b_count", 96'(b_count), 96'(mc[1]));
  endtask

  // Caller sets inputs at a falling edge; this advances one cycle and checks.
  task automatic cyc();
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(logic r, logic e, logic w, logic rdy);
    rst = r; en = e; seed_we = w; out_ready = rdy;
  endtask

  logic [95:0] first_sample;

  initial begin
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    ch = '0; sd0 = '0; sd1 = '0; sd2 = '0;
    @(negedge clk);
    cyc();
    cyc();
    check_eq("rst_valid", 96'(a_valid), 96'(0));
    check_eq("rst_data",  96'(a_data),  96'(0));
    check_eq("rst_count", 96'(a_count), 96'(0));

    // Startup latency and 1000 back-to-back transfers.
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    cyc();
    check_eq("lat_valid", 96'(a_valid), 96'(1));
    first_sample = md[0];
    for (int n = 0; n < 1000; n++) cyc();
    check_eq("cnt_1000", 96'(a_count), 96'(1000));

    // Backpressure: output frozen for 20 cycles, then resumes with the next sample.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) cyc();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) cyc();

    // Seed load to channel 1 during a handshake: transfer counts, valid falls.
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    ch = 2'd1; sd0 = $urandom; sd1 = $urandom; sd2 = $urandom;
    cyc();
    check_eq("seed_vfall", 96'(a_valid), 96'(0));
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 10; n++) cyc();

    // Zero seeds exercise the fix-up path; golden words are fixed constants.
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    ch = 2'd0; sd0 = '0; sd1 = '0; sd2 = '0;
    cyc();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    cyc();
    check_eq("fix_a1", 96'(a_data[31:0]), 96'(32'h00202080));
    check_eq("fix_b1", 96'(b_data[7:0]),  96'(8'h00));
    cyc();
    check_eq("fix_a2", 96'(a_data[31:0]), 96'(32'h02002C80));
    check_eq("fix_b2", 96'(b_data[7:0]),  96'(8'h02));

    // Invalid channel on the 3-channel instance: stalls, loads nothing there.
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    ch = 2'd3; sd0 = $urandom; sd1 = $urandom; sd2 = $urandom;
    cyc();
    check_eq("inv_stall", 96'(b_valid), 96'(0));
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) cyc();

    // Randomised mix of enable, backpressure and seed loads.
    for (int n = 0; n < 3000; n++) begin
      drive(1'b0, ($urandom % 8) != 0, ($urandom % 16) == 0, ($urandom % 4) != 0);
      ch  = 2'($urandom);
      sd0 = (($urandom % 4) == 0) ? $urandom % 20 : $urandom;
      sd1 = (($urandom % 4) == 0) ? $urandom % 20 : $urandom;
      sd2 = (($urandom % 4) == 0) ? $urandom % 20 : $urandom;
      cyc();
    end

    // Counter wrap: preset the count to all-ones while nothing transfers.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    force dut_a.count_q = 32'hFFFF_FFFF;
    mc[0] = 32'hFFFF_FFFF;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    release dut_a.count_q;
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    cyc();
    check_eq("wrap_cnt", 96'(a_count), 96'(0));
    cyc();

    // Mid-stream reset with a pending sample, then replay from the reset seeds.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    cyc();
    check_eq("mrst_valid", 96'(a_valid), 96'(0));
    check_eq("mrst_data",  96'(a_data),  96'(0));
    check_eq("mrst_count", 96'(a_count), 96'(0));
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    cyc();
    check_eq("replay", 96'(a_data), first_sample);
    for (int n = 0; n < 20; n++) cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/taus_urng_bank.md
# taus_urng_bank

Multi-channel, registered Tausworthe (three-component LFSR, 88-bit state per channel) uniform random number generator with per-channel seeding and a valid/ready output stream. It is the clocked, parametrised successor to the combinational single-step URNG. It holds its own state, so the generator advances itself instead of the upstream logic feeding back seeds. Downstream it feeds the Box-Muller / AWGN datapath, one uniform word per channel per accepted transfer.

## Interface
- NUM_CH, 2: number of independent generator channels (1..16).
- OUT_W, 32: bits emitted per channel (1..32); the top OUT_W bits of each 32-bit uniform word.
- SEED0, 32'hF111F111: base reset seed for component 0.
- SEED1, 32'h07770777: base reset seed for component 1.
- SEED2, 32'hE888E888: base reset seed for component 2.
- CH_W (localparam): max(1, clog2(NUM_CH)).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  permits advancing; 0 freezes all state (output register still handshakes).
- seed_we  in  1  load seeds into channel seed_ch this cycle.
- seed_ch  in  CH_W  target channel; values >= NUM_CH are ignored (no load, but the stall still applies).
- seed_s0, seed_s1, seed_s2  in  32 each  seed words.
- out_valid  out  1  out_data holds an unconsumed sample set.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_data  out  NUM_CH*OUT_W  channel k in bits [k*OUT_W +: OUT_W].
- out_count  out  32  number of accepted transfers, wraps modulo 2^32.

## Operation
- **Per-channel state.** Each channel holds s0, s1, s2 (32 bits each). One step, all arithmetic modulo 2^32, with bits shifted past bit 31 discarded:
  - b0 = ((s0<<13)^s0)>>19; s0' = ((s0&FFFFFFFE)<<12)^b0.
  - b1 = ((s1<<2)^s1)>>25; s1' = ((s1&FFFFFFF8)<<4)^b1.
  - b2 = ((s2<<3)^s2)>>11; s2' = ((s2&FFFFFFF0)<<17)^b2.
  - u = s0'^s1'^s2'.
- **Seed fix-up.** Applied on every load, at reset and via seed_we. It prevents degenerate components:
  - if s0<2, s0 += 2;
  - if s1<8, s1 += 8;
  - if s2<16, s2 += 16.
- **Reset seeds.** Channel k loads fixup(SEEDn ^ (k*32'h9E3779B9)) for n = 0, 1, 2.
- **Advance condition.** adv = en & ~seed_we & (~out_valid | out_ready). On adv, every channel steps: state <= next state, out_data slice <= u[31:32-OUT_W], and out_valid <= 1.
- **Drain.** If out_valid & out_ready & ~adv, out_valid <= 0.
- **Seed load.** seed_we has priority over adv. No channel steps that cycle. The out_data register is untouched, and a handshake that cycle completes normally. The newly seeded channel's first output is produced at the next adv.
- **Output stability.** While out_valid=1 and out_ready=0, out_data must not change, whatever en or seed_we do.
- **Transfer counter.** out_count increments on each out_valid & out_ready.
- **Mode flag.** A single internal flag has two values, EMPTY (out_valid=0) and FULL (out_valid=1). EMPTY->FULL on adv. FULL->EMPTY on a handshake without adv. FULL->FULL on a handshake with adv (back-to-back throughput of 1 sample set per cycle).

## Timing
- **Reset values:** out_valid=0, out_data=0, out_count=0, state = fix-up of the reset seeds.
- **Startup latency:** with en=1 and no stalls, out_valid rises 1 cycle after rst deasserts. The first out_data is the first step from the reset seeds.
- **Throughput:** a sustained rate of one sample set per clk while out_ready=1, en=1, seed_we=0.
- **Simultaneous events:**
  - rst overrides everything, including seed_we.
  - seed_we together with a handshake: the transfer counts and out_valid falls.
  - en=0 together with a handshake: out_valid falls.
- **Reset mid-stream:** the next cycle shows out_valid=0, out_count=0 and the sequence restarts from the reset seeds; any pending sample is discarded.
- **Counter wrap:** out_count goes 32'hFFFFFFFF -> 0 with no flag.

## Test plan
- **Fix-up sequence.** NUM_CH=1, OUT_W=32. Load seed_we with seeds 0/0/0, then hold out_ready=1 and en=1. Required: first out_data=32'h00202080, second=32'h02002C80.
- **Post-reset latency and golden model.** Default parameters: out_valid=0 during rst and goes 1 exactly one cycle after rst falls. 1000 back-to-back transfers must match the bit-exact golden model for both channels; out_count=1000.
- **Backpressure.** Hold out_ready=0 for 20 cycles with en=1. Required: out_data is constant, state does not advance, and the next sample after release equals the golden model's next sample.
- **Seed priority.** Assert seed_we to channel 1 with out_valid=1 and out_ready=1. Required: the transfer counts and out_valid=0 the next cycle. Channel 0 continues its sequence unbroken; channel 1 restarts from the fixed-up seeds.
- **Invalid and truncated output.** With NUM_CH=3, seed_we with seed_ch=3 changes no state but stalls one cycle. With OUT_W=8, each slice equals u[31:24] of the golden model.
- **Counter wrap and mid-run reset.** Force out_count to 32'hFFFFFFFF and complete one transfer: out_count must read 0. Then assert rst while out_valid=1: outputs return to reset values next cycle and the sequence replays from the reset seeds.
